// File: rtl/gcd_ctrl_if.sv
// Handshake bundle between the GCD control FSM (master) and the datapath/requester side (slave).
interface gcd_ctrl_if #(
  parameter int CNT_W = 5
);
  logic             go;
  logic             eqflg;
  logic             ltflg;
  logic             xmsel;
  logic             ymsel;
  logic             xld;
  logic             yld;
  logic             gld;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] iters;

  modport master (
    input  go, eqflg, ltflg,
    output xmsel, ymsel, xld, yld, gld, busy, done, timeout, iters
  );

  modport slave (
    output go, eqflg, ltflg,
    input  xmsel, ymsel, xld, yld, gld, busy, done, timeout, iters
  );
endinterface

// File: rtl/gcd_ctrl.sv
// Control FSM for the subtractive 4-bit GCD datapath.
// Optional watchdog abort is enabled by defining GCD_CTRL_WDOG_EN.
module gcd_ctrl #(
  parameter int CNT_W      = 5,
  parameter int WDOG_LIMIT = 31
) (
  input  logic         clk,
  input  logic         clr,
  gcd_ctrl_if.master   bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  localparam logic [CNT_W-1:0] ITERS_MAX = '1;
  localparam logic [CNT_W-1:0] WDOG_CNT  = CNT_W'(WDOG_LIMIT);
`ifdef GCD_CTRL_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  state_t           state;
  logic             busy_q;
  logic             done_q;
  logic             timeout_q;
  logic [CNT_W-1:0] iters_q;
  logic             wdog_hit;
  logic             xmsel_c;
  logic             ymsel_c;
  logic             xld_c;
  logic             yld_c;
  logic             gld_c;

  // An equal-flag result always wins over the watchdog abort.
  assign wdog_hit = WDOG_ON && !bus.eqflg && (iters_q == WDOG_CNT);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      iters_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q    <= 1'b0;
          timeout_q <= 1'b0;
          if (bus.go) begin
            state   <= LOAD;
            busy_q  <= 1'b1;
            iters_q <= '0;
          end
        end
        LOAD: begin
          state <= CALC;
        end
        CALC: begin
          if (bus.eqflg) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (wdog_hit) begin
            state     <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else if (iters_q != ITERS_MAX) begin
            iters_q <= iters_q + CNT_W'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          done_q    <= 1'b0;
          timeout_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Load enables must react to the flags within the same CALC cycle.
  always_comb begin
    xmsel_c = 1'b0;
    ymsel_c = 1'b0;
    xld_c   = 1'b0;
    yld_c   = 1'b0;
    gld_c   = 1'b0;
    case (state)
      LOAD: begin
        xmsel_c = 1'b1;
        ymsel_c = 1'b1;
        xld_c   = 1'b1;
        yld_c   = 1'b1;
      end
      CALC: begin
        if (bus.eqflg)      gld_c = 1'b1;
        else if (wdog_hit)  gld_c = 1'b0;
        else if (bus.ltflg) yld_c = 1'b1;
        else                xld_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.xmsel   = xmsel_c;
  assign bus.ymsel   = ymsel_c;
  assign bus.xld     = xld_c;
  assign bus.yld     = yld_c;
  assign bus.gld     = gld_c;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.timeout = timeout_q;
  assign bus.iters   = iters_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Self-checking bench for gcd_ctrl: a behavioural 4-bit datapath closes the loop and
// every run is compared against an arithmetic GCD reference.
module tb_gcd_ctrl;

  localparam int CNT_W      = 5;
  localparam int WDOG_LIMIT = 31;
  localparam int ITERS_MAX  = (1 << CNT_W) - 1;
  localparam int CYC_BUDGET = 60;

  logic       clk  = 1'b0;
  logic       clr  = 1'b1;
  logic [3:0] xin  = '0;
  logic [3:0] yin  = '0;
  logic [3:0] xreg = '0;
  logic [3:0] yreg = '0;
  logic [3:0] greg = '0;
  logic [3:0] last_g = '0;
  int         compared   = 0;
  int         mismatched = 0;

  always #5 clk = ~clk;

  gcd_ctrl_if #(.CNT_W(CNT_W)) bus ();

  gcd_ctrl #(.CNT_W(CNT_W), .WDOG_LIMIT(WDOG_LIMIT)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Datapath model driven by the controller's selects and enables.
  always @(posedge clk) begin
    if (bus.xld) xreg <= bus.xmsel ? xin : xreg - yreg;
    if (bus.yld) yreg <= bus.ymsel ? yin : yreg - xreg;
    if (bus.gld) greg <= xreg;
  end
  assign bus.eqflg = (xreg == yreg);
  assign bus.ltflg = (xreg < yreg);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] outs();
    return {bus.xmsel, bus.ymsel, bus.xld, bus.yld, bus.gld,
            bus.busy, bus.done, bus.timeout, bus.iters};
  endfunction

  // Euclid by repeated subtraction, counting each kind of step; stops early at the watchdog limit.
  function automatic void refModel(input int x, input int y, output int xs, output int ys,
                                   output int g, output bit to);
    int a = x;
    int b = y;
    int limit;
`ifdef GCD_CTRL_WDOG_EN
    limit = WDOG_LIMIT;
`else
    limit = 1000;
`endif
    xs = 0;
    ys = 0;
    while (a != b && xs + ys < limit) begin
      if (a < b) begin b -= a; ys++; end
      else       begin a -= b; xs++; end
    end
    to = (a != b);
    g  = a;
  endfunction

  task automatic applyStimulus(input logic [3:0] x, input logic [3:0] y, input bit hold_go);
    int xs, ys, g, n, exp_iters;
    bit to;
    int done_cyc = -1;
    int xld_cnt = 0, yld_cnt = 0, gld_cnt = 0, bad = 0;
    logic to_seen = 1'b0;
    logic [CNT_W-1:0] iters_seen = '0;
    refModel(int'(x), int'(y), xs, ys, g, to);
    n = xs + ys;
    @(negedge clk);
    xin = x;
    yin = y;
    bus.go = 1'b1;
    for (int cyc = 1; cyc <= CYC_BUDGET && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (!hold_go) bus.go = 1'b0;
      if (cyc == 1) begin
        checkOutput("load_ctl", 32'({bus.xmsel, bus.ymsel, bus.xld, bus.yld, bus.gld, bus.busy}),
                    32'b111101);
        checkOutput("load_iters", 32'(bus.iters), 0);
      end else begin
        if (int'(bus.xld) + int'(bus.yld) + int'(bus.gld) > 1 || bus.xmsel || bus.ymsel) bad++;
        xld_cnt += int'(bus.xld);
        yld_cnt += int'(bus.yld);
        gld_cnt += int'(bus.gld);
        if (bus.done) begin
          done_cyc   = cyc;
          to_seen    = bus.timeout;
          iters_seen = bus.iters;
        end
      end
    end
    if (done_cyc < 0) begin
      checkOutput("done_seen", 0, 1);
    end else begin
      exp_iters = to ? WDOG_LIMIT : ((n > ITERS_MAX) ? ITERS_MAX : n);
      checkOutput("done_cycle", done_cyc, to ? WDOG_LIMIT + 3 : n + 3);
      checkOutput("iters", 32'(iters_seen), exp_iters);
      checkOutput("timeout", 32'(to_seen), 32'(to));
      checkOutput("xld_count", xld_cnt, xs);
      checkOutput("yld_count", yld_cnt, ys);
      checkOutput("gld_count", gld_cnt, to ? 0 : 1);
      checkOutput("one_hot_ld", bad, 0);
      checkOutput("greg", 32'(greg), to ? 32'(last_g) : g);
      if (!to) last_g = 4'(g);
    end
  endtask

  initial begin
    logic [3:0] rx, ry;
    int dn;
    bus.go = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_outs", 32'(outs()), 0);
    clr = 1'b0;

    applyStimulus(4'd9, 4'd9, 1'b0);
    applyStimulus(4'd12, 4'd8, 1'b0);
    applyStimulus(4'd15, 4'd1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      rx = 4'($urandom_range(1, 15));
      ry = 4'($urandom_range(1, 15));
      applyStimulus(rx, ry, 1'b0);
    end

`ifdef GCD_CTRL_WDOG_EN
    applyStimulus(4'd0, 4'd5, 1'b0);
`else
    // Zero operand never converges: controller stays busy with a saturated count.
    @(negedge clk);
    xin = 4'd0;
    yin = 4'd5;
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    dn = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    checkOutput("zero_no_done", dn, 0);
    checkOutput("zero_iters_sat", 32'(bus.iters), ITERS_MAX);
    checkOutput("zero_busy", 32'(bus.busy), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
`endif

    // Asynchronous clear in the third CALC cycle of a 15/1 run.
    @(negedge clk);
    xin = 4'd15;
    yin = 4'd1;
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre_clr_busy", 32'(bus.busy), 1);
    clr = 1'b1;
    #1;
    checkOutput("clr_outs", 32'(outs()), 0);
    @(negedge clk);
    clr = 1'b0;
    applyStimulus(4'd6, 4'd4, 1'b0);

    // go held high through a whole run: one idle cycle after done, then a fresh LOAD.
    applyStimulus(4'd6, 4'd4, 1'b1);
    @(negedge clk);
    checkOutput("held_idle", 32'({bus.busy, bus.xld, bus.yld, bus.xmsel, bus.done}), 0);
    @(negedge clk);
    checkOutput("held_reload", 32'({bus.xmsel, bus.ymsel, bus.xld, bus.yld, bus.busy}), 32'b11111);
    bus.go = 1'b0;
    dn = 0;
    for (int c = 0; c < 20 && dn == 0; c++) begin
      @(negedge clk);
      if (bus.done) dn = 1;
    end
    checkOutput("rerun_done", dn, 1);
    checkOutput("rerun_greg", 32'(greg), 2);
    checkOutput("rerun_iters", 32'(bus.iters), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gcd_ctrl.md
# gcd_ctrl

Control FSM for the subtractive 4-bit GCD datapath. It accepts a start request, sequences operand load, repeated subtraction and result capture using the datapath's equal and less-than flags, and reports completion with a one-cycle `done` pulse and an iteration count. The block sits beside the datapath. It drives the datapath's mux-select and load-enable inputs and consumes its `eqflg`/`ltflg` outputs.

## Interface
- `CNT_W`, default 5: width of the iteration counter `iters`.
- `WDOG_LIMIT`, default 31: number of subtraction cycles after which the watchdog aborts. Must be ≤ 2^CNT_W−1.

Ports:
- `clk`, input, 1: clock; all state changes on the rising edge.
- `clr`, input, 1: reset; asynchronous, active-high.
- `go`, input, 1: start request, sampled only in IDLE.
- `eqflg`, input, 1: datapath xreg==yreg (combinational from datapath registers).
- `ltflg`, input, 1: datapath xreg<yreg.
- `xmsel`, output, 1: 1 selects external x operand, 0 selects x−y.
- `ymsel`, output, 1: 1 selects external y operand, 0 selects y−x.
- `xld`, output, 1: x register load enable.
- `yld`, output, 1: y register load enable.
- `gld`, output, 1: result register load enable (captures xreg).
- `busy`, output, 1: high in LOAD and CALC.
- `done`, output, 1: one-cycle completion pulse.
- `timeout`, output, 1: high together with `done` when the run was aborted by the watchdog.
- `iters`, output, CNT_W: number of subtraction cycles in the current or last run.

## Operation
- States: IDLE, LOAD, CALC, DONE. Reset state is IDLE.
- IDLE:
  - All control outputs are 0.
  - `go`=1 → LOAD; otherwise stay.
- LOAD (one cycle):
  - `xmsel`=`ymsel`=`xld`=`yld`=1; `iters` cleared to 0.
  - Next state is CALC.
- CALC uses Mealy decode on the flags each cycle, in priority order:
  - `eqflg`=1 → `gld`=1, next DONE.
  - Else `ltflg`=1 → `yld`=1, `ymsel`=0 (y←y−x), stay, `iters`+1.
  - Else → `xld`=1, `xmsel`=0 (x←x−y), stay, `iters`+1.
- `iters` saturates at 2^CNT_W−1 and never wraps. It holds its value after DONE until the next LOAD.
- DONE (one cycle):
  - `done`=1, next IDLE.
  - If `go` is still high in the following IDLE cycle, a new run starts.
- `go` is ignored outside IDLE.
- At most one of `xld`/`yld`/`gld` is asserted in any CALC cycle.
- `xmsel`/`ymsel` are 0 in every state except LOAD.

## Timing
- `clr` asserted, at any time including mid-run:
  - FSM returns to IDLE immediately.
  - All outputs go to 0: `xmsel`, `ymsel`, `xld`, `yld`, `gld`, `busy`, `done`, `timeout` and `iters`.
- Define `go` as sampled at edge 0:
  - LOAD in cycle 1.
  - First CALC in cycle 2.
  - N subtraction cycles occupy cycles 2…N+1.
  - `gld` is asserted in cycle N+2.
  - `done` is asserted in cycle N+3; the result register holds the GCD from that cycle.
- Total latency from `go` to `done` is N+3 cycles.
- Flags are read in the same cycle they are produced. No pipelining is assumed between datapath registers and flags.

## Configuration
- `GCD_CTRL_WDOG_EN` defined:
  - In CALC, if `iters`==WDOG_LIMIT and `eqflg`=0, assert no load and go to DONE.
  - In that DONE cycle, `timeout`=1; the result register is unchanged.
  - `timeout` is 0 in every other cycle.
  - This check takes priority over the subtraction decode; `eqflg`=1 still wins.
- `GCD_CTRL_WDOG_EN` undefined:
  - `timeout` is tied to 0.
  - A zero operand keeps CALC running indefinitely until `clr`.

## Test plan
- x=9, y=9, `go` pulse → `gld` in cycle 2, `done` in cycle 3, `iters`=0, greg=9.
- x=12, y=8 → sequence x←4, then y←4, then `gld`; `done` in cycle 5, `iters`=2, greg=4.
- x=15, y=1 → 14 x-subtractions, `done` in cycle 17, `iters`=14, greg=1; `yld` never asserted.
- x=0, y=5 with `GCD_CTRL_WDOG_EN` → 31 `yld` cycles, then `done`=1 with `timeout`=1 in cycle 34; greg keeps its prior value.
- `clr` pulsed in the 3rd CALC cycle of the 15/1 run → all outputs 0 and IDLE; a new `go` with 6/4 yields greg=2, `iters`=2.
- `go` held high through a 6/4 run → `go` ignored while `busy`; a second LOAD follows the cycle after DONE.
